// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised oversampling UART receiver with 3-sample majority voting,
// false-start rejection and a valid/ready holding register. Define UART_RX_PARITY_EN for parity checking.
module uart_rx_ext #(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    input  logic            i_ready,
    input  logic            i_ovr_clr,
`ifdef UART_RX_PARITY_EN
    input  logic            i_parity_odd,
    output logic            o_parity_err,
`endif
    output logic [DBIT-1:0] o_data,
    output logic            o_valid,
    output logic            o_frame_err,
    output logic            o_overrun,
    output logic            o_busy
);

    localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT);

    localparam logic [SW-1:0] S_SAMP0    = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_SAMP1    = SW'(OVS / 2);
    localparam logic [SW-1:0] S_SAMP2    = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0] S_BIT_END  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state, state_next;
    logic [SW-1:0]   s, s_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic [2:0]      votes, votes_next;
    logic            rx_meta, rx_s;
    logic            third, maj;
    logic            frame_done, frame_load, frame_drop;
`ifdef UART_RX_PARITY_EN
    logic            p_reg, p_next;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b_reg <= '0;
            votes <= '0;
`ifdef UART_RX_PARITY_EN
            p_reg <= 1'b0;
`endif
        end else if (i_s_tick) begin
            state <= state_next;
            s     <= s_next;
            n     <= n_next;
            b_reg <= b_next;
            votes <= votes_next;
`ifdef UART_RX_PARITY_EN
            p_reg <= p_next;
`endif
        end
    end

    // The third vote is taken from the live line when the bit ends on that same tick (OVS=4).
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b_reg;
        votes_next = votes;
        frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
        p_next     = p_reg;
`endif
        third = (s == S_SAMP2) ? rx_s : votes[2];
        maj   = (votes[0] & votes[1]) | (votes[0] & third) | (votes[1] & third);

        if (s == S_SAMP0) votes_next[0] = rx_s;
        if (s == S_SAMP1) votes_next[1] = rx_s;
        if (s == S_SAMP2) votes_next[2] = rx_s;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if ((s == S_SAMP0) && rx_s) begin
                    state_next = IDLE;
                    s_next     = '0;
                end else if (s == S_BIT_END) begin
                    state_next = DATA;
                    s_next     = '0;
                    n_next     = '0;
                end else begin
                    s_next = s + 1'b1;
                end
            end
            DATA: begin
                if (s == S_BIT_END) begin
                    b_next = {maj, b_reg[DBIT-1:1]};
                    s_next = '0;
                    if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        n_next = n + 1'b1;
                    end
                end else begin
                    s_next = s + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s == S_BIT_END) begin
                    p_next     = maj;
                    s_next     = '0;
                    state_next = STOP;
                end else begin
                    s_next = s + 1'b1;
                end
            end
`endif
            STOP: begin
                if (s == S_STOP_END) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                    s_next     = '0;
                end else begin
                    s_next = s + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                s_next     = '0;
            end
        endcase
    end

    assign frame_load = i_s_tick && frame_done && (!o_valid || i_ready);
    assign frame_drop = i_s_tick && frame_done && o_valid && !i_ready;

    // A completed frame may load in the same cycle the previous word is popped.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
        end else begin
            if (frame_load) begin
                o_data      <= b_reg;
                o_frame_err <= ~maj;
                o_valid     <= 1'b1;
`ifdef UART_RX_PARITY_EN
                o_parity_err <= (^b_reg) ^ p_reg ^ i_parity_odd;
`endif
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (frame_drop) begin
                o_overrun <= 1'b1;
            end else if (i_ovr_clr) begin
                o_overrun <= 1'b0;
            end
        end
    end

    assign o_busy = (state != IDLE);

endmodule
